// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and sizes for the decoder scan controller.
// State encoding plus channel-count constants used by the top, finder and interface.
package decoder_scan_pkg;

  localparam int NCHAN = 16;
  localparam int IDXW  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan requester and the decoder scan controller.
// master = requester (drives start/stop/config), slave = controller (drives decoder address/status).
interface decoder_scan_ctrl_if import decoder_scan_pkg::*; #(
  parameter int DW = 8
);

  logic             start;
  logic             stop;
  logic             mode_cont;
  logic [NCHAN-1:0] chan_mask;
  logic [DW-1:0]    dwell;
  logic             sel_a1;
  logic             sel_a2;
  logic             sel_a3;
  logic             sel_w;
  logic             sel_en;
  logic [IDXW-1:0]  chan_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, mode_cont, chan_mask, dwell,
    input  sel_a1, sel_a2, sel_a3, sel_w, sel_en, chan_idx, busy, done
  );

  modport slave (
    input  start, stop, mode_cont, chan_mask, dwell,
    output sel_a1, sel_a2, sel_a3, sel_w, sel_en, chan_idx, busy, done
  );

endinterface

// File: rtl/decoder_scan_ctrl_next_chan_finder.sv
// Combinational priority search: lowest set mask bit above cur (or at/above cur when incl),
// optionally wrapping to the lowest set bit overall when nothing lies above.
module next_chan_finder import decoder_scan_pkg::*; (
  input  logic [NCHAN-1:0] mask,
  input  logic [IDXW-1:0]  cur,
  input  logic             incl,
  input  logic             wrap,
  output logic             found,
  output logic [IDXW-1:0]  next
);

  logic            above_vld;
  logic            low_vld;
  logic [IDXW-1:0] above_idx;
  logic [IDXW-1:0] low_idx;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    above_vld = 1'b0;
    above_idx = '0;
    low_vld   = 1'b0;
    low_idx   = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_vld = 1'b1;
        low_idx = IDXW'(i);
        if ((IDXW'(i) > cur) || (incl && (IDXW'(i) == cur))) begin
          above_vld = 1'b1;
          above_idx = IDXW'(i);
        end
      end
    end
  end

  assign found = above_vld | (wrap & low_vld);
  assign next  = above_vld ? above_idx : low_idx;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans the 16 outputs of a 4-to-16 one-hot decoder in order, skipping masked channels,
// holding the decoder enable low for BLANK_CYC cycles around every address change.
module decoder_scan_ctrl import decoder_scan_pkg::*; #(
  parameter int DW        = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  decoder_scan_ctrl_if.slave bus
);

  localparam int             BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0]  BLANK_LAST = BW'(BLANK_CYC - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;

  logic            first_vld, nxt_vld;
  logic [IDXW-1:0] first_idx, nxt_idx;
  logic [DW-1:0]   dwell_eff;

  next_chan_finder u_first (
    .mask  (bus.chan_mask),
    .cur   ('0),
    .incl  (1'b1),
    .wrap  (1'b0),
    .found (first_vld),
    .next  (first_idx)
  );

  next_chan_finder u_next (
    .mask  (bus.chan_mask),
    .cur   (idx_q),
    .incl  (1'b0),
    .wrap  (bus.mode_cont),
    .found (nxt_vld),
    .next  (nxt_idx)
  );

  assign dwell_eff = (bus.dwell == '0) ? DW'(1) : bus.dwell;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    // stop overrides everything, including a simultaneous start in IDLE.
    if (bus.stop) begin
      state_d = IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (first_vld) begin
              idx_d   = first_idx;
              state_d = BLANK;
              busy_d  = 1'b1;
              bcnt_d  = BLANK_LAST;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        BLANK: begin
          if (bcnt_q == '0) begin
            state_d = DRIVE;
            en_d    = 1'b1;
            dcnt_d  = dwell_eff;
          end else begin
            bcnt_d = bcnt_q - BW'(1);
          end
        end
        DRIVE: begin
          if (dcnt_q <= DW'(1)) begin
            en_d = 1'b0;
            if (nxt_vld) begin
              idx_d   = nxt_idx;
              state_d = BLANK;
              bcnt_d  = BLANK_LAST;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign bus.sel_a1   = idx_q[3];
  assign bus.sel_a2   = idx_q[2];
  assign bus.sel_a3   = idx_q[1];
  assign bus.sel_w    = idx_q[0];
  assign bus.sel_en   = en_q;
  assign bus.chan_idx = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: directed scenarios plus randomized traffic against a slot-based model.
module tb_decoder_scan_ctrl;
  import decoder_scan_pkg::*;

  localparam int DW        = 8;
  localparam int BLANK_CYC = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_scan_ctrl_if #(.DW(DW)) bus();

  decoder_scan_ctrl #(.DW(DW), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_from(input logic [15:0] m, input int from);
    for (int i = from; i < 16; i++)
      if (m[i]) return i;
    return -1;
  endfunction

  // Model: a scan is a sequence of channel slots; each slot is BLANK_CYC blank cycles
  // followed by max(dwell,1) driven cycles, m_t counting cycles spent in the slot.
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_ch   = 0;
  int m_t    = 0;
  int m_dw   = 1;
  int c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_ch = 0; m_t = 0; m_dw = 1;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (bus.start && !bus.stop) begin
          c = lowest_from(bus.chan_mask, 0);
          if (c < 0) m_done = 1'b1;
          else begin m_busy = 1'b1; m_ch = c; m_t = 0; end
        end
      end else if (bus.stop) begin
        m_busy = 1'b0;
      end else begin
        m_t++;
        if (m_t == BLANK_CYC) begin
          m_dw = (bus.dwell == 0) ? 1 : int'(bus.dwell);
        end else if (m_t == BLANK_CYC + m_dw) begin
          c = lowest_from(bus.chan_mask, m_ch + 1);
          if (c < 0 && bus.mode_cont) c = lowest_from(bus.chan_mask, 0);
          if (c < 0) begin m_busy = 1'b0; m_done = 1'b1; end
          else begin m_ch = c; m_t = 0; end
        end
      end
    end
  end

  logic            p_en  = 1'b0;
  logic [IDXW-1:0] p_idx = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_en = 1'b0;
    end else if (chk_on) begin
      chk("chan_idx", bus.chan_idx, m_ch);
      chk("addr", {bus.sel_a1, bus.sel_a2, bus.sel_a3, bus.sel_w}, m_ch);
      chk("sel_en", bus.sel_en, (m_busy && m_t >= BLANK_CYC));
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      if (bus.sel_en && !p_en) chk("rise_addr_stable", bus.chan_idx, p_idx);
      p_en  = bus.sel_en;
      p_idx = bus.chan_idx;
    end
  end

  int n_en, n_done, first_en, done_at, nexp, got;
  bit order_ok, hit;
  logic pe;
  int seq_exp [7] = '{0, 8, 15, 0, 8, 15, 0};

  task automatic wait_drive(input int ch, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.sel_en && bus.chan_idx == IDXW'(ch)) ok = 1'b1;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode_cont = 1'b0;
    bus.chan_mask = '0; bus.dwell = '0;
    repeat (2) @(negedge clk);
    chk("rst_chan_idx", bus.chan_idx, 0);
    chk("rst_sel_en", bus.sel_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Full single pass, dwell 2.
    bus.chan_mask = 16'hFFFF; bus.dwell = 8'd2; bus.mode_cont = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    n_en = 0; n_done = 0; first_en = -1; done_at = -1; nexp = 0; order_ok = 1'b1; pe = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.sel_en) begin n_en++; if (first_en < 0) first_en = n; end
      if (bus.sel_en && !pe) begin
        if (bus.chan_idx != IDXW'(nexp)) order_ok = 1'b0;
        nexp++;
      end
      pe = bus.sel_en;
      if (bus.done) begin n_done++; if (done_at < 0) done_at = n; end
    end
    chk("t1_first_en_edges", first_en, 1 + BLANK_CYC);
    chk("t1_done_after_start", done_at - 1, 48);
    chk("t1_en_cycles", n_en, 32);
    chk("t1_visits", nexp, 16);
    chk("t1_order", order_ok, 1);
    chk("t1_done_pulses", n_done, 1);

    // Continuous scan over 0, 8, 15 with wrap, then stop while 8 is driven.
    bus.chan_mask = 16'h8101; bus.dwell = 8'd1; bus.mode_cont = 1'b1;
    @(negedge clk); bus.start = 1'b1;
    got = 0; n_done = 0; pe = 1'b0;
    for (int n = 0; n < 60 && got < 7; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) n_done++;
      if (bus.sel_en && !pe) begin
        chk("t2_seq", bus.chan_idx, seq_exp[got]);
        got++;
      end
      pe = bus.sel_en;
    end
    chk("t2_visits", got, 7);
    wait_drive(8, 20, hit);
    chk("t2_reach_8", hit, 1);
    chk("t2_no_done", n_done, 0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("t2_stop_en", bus.sel_en, 0);
    chk("t2_stop_busy", bus.busy, 0);
    chk("t2_stop_done", bus.done, 0);

    // Empty mask: immediate done, no scan.
    bus.chan_mask = 16'h0000; bus.mode_cont = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("t3_done", bus.done, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_en", bus.sel_en, 0);
    @(negedge clk);
    chk("t3_done_one_cycle", bus.done, 0);

    // Dwell 0 behaves as 1 on a single channel.
    bus.chan_mask = 16'h0010; bus.dwell = 8'd0;
    @(negedge clk); bus.start = 1'b1;
    n_en = 0; n_done = 0; got = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.sel_en) begin n_en++; got = int'(bus.chan_idx); end
      if (bus.done) n_done++;
    end
    chk("t4_en_cycles", n_en, 1);
    chk("t4_chan", got, 4);
    chk("t4_done", n_done, 1);

    // Clearing upper mask bits mid-scan ends the pass after the current channel.
    bus.chan_mask = 16'hFFFF; bus.dwell = 8'd1; bus.mode_cont = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    wait_drive(5, 40, hit);
    chk("t5_reach_5", hit, 1);
    bus.chan_mask = 16'h003F;
    @(negedge clk);
    chk("t5_done", bus.done, 1);
    chk("t5_chan", bus.chan_idx, 5);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 15) < 3);
      bus.stop  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.chan_mask = 16'($urandom);
          1: bus.chan_mask = 16'h0000;
          2: bus.chan_mask = 16'h1 << $urandom_range(0, 15);
          default: bus.chan_mask = 16'hFFFF;
        endcase
      end
      bus.dwell     = DW'($urandom_range(0, 3));
      bus.mode_cont = 1'($urandom_range(0, 1));
    end
    @(negedge clk); bus.start = 1'b0; bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;

    // Asynchronous reset in the middle of DRIVE.
    bus.chan_mask = 16'hFFFF; bus.dwell = 8'd3; bus.mode_cont = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    wait_drive(1, 20, hit);
    chk("t6_reach_drive", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_en", bus.sel_en, 0);
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_idx", bus.chan_idx, 0);
    #14 rst_n = 1'b1;
    @(negedge clk);
    bus.chan_mask = 16'h0300; bus.dwell = 8'd1;
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("t6_post_busy", bus.busy, 1);
    chk("t6_post_blank_en", bus.sel_en, 0);
    @(negedge clk);
    chk("t6_post_en", bus.sel_en, 1);
    chk("t6_post_idx", bus.chan_idx, 8);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
